ysyx_23060208_sram_rd_arbiter: RTL and testbench

//  Shares one AXI4-Lite-style SRAM read port (AR/R channels) between IFU (instruction

---
 rtl/ysyx_23060208_sram_rd_arbiter_if.sv | 24 ++
 rtl/ysyx_23060208_sram_rd_arbiter.sv | 133 +++++++++++++
 tb/tb_ysyx_23060208_sram_rd_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060208_sram_rd_arbiter_if.sv
// AR/R read-channel bundle shared by the IFU, the LSU and the SRAM read port.
// The master modport is the side that issues addresses and accepts data; the
// slave modport is the side that accepts addresses and returns data.
interface ysyx_23060208_sram_rd_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ysyx_23060208_sram_rd_arbiter.sv
// Read-port arbiter: IFU and LSU share one SRAM AR/R port. One transaction is in
// flight at a time; the owner keeps the grant from arbitration until its R
// handshake, and there is one idle bubble cycle after every R handshake.
// Optional macro ARB_ROUND_ROBIN_EN: on simultaneous requests the requester that
// was not served last wins. Without it the LSU always beats the IFU.
module ysyx_23060208_sram_rd_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    ysyx_23060208_sram_rd_arbiter_if.slave         ifu,
    ysyx_23060208_sram_rd_arbiter_if.slave         lsu,
    ysyx_23060208_sram_rd_arbiter_if.master        sram,
    output logic [1:0]                             grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            grant_d;
    logic                  lsu_wins;
    logic                  owner_lsu;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] owner_araddr;

    // grant is one-hot, so its LSU bit alone identifies the owner
    assign owner_lsu    = grant[1];
    assign owner_araddr = owner_lsu ? lsu.araddr : ifu.araddr;
    assign r_done       = (state_q == RESP) && sram.rvalid && sram.rready;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_lsu_q;

    // Remember who completed the most recent transaction so a tie goes to the other side
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_lsu_q <= 1'b0;
        end else if (r_done) begin
            last_owner_lsu_q <= owner_lsu;
        end
    end

    assign lsu_wins = lsu.arvalid && (!ifu.arvalid || !last_owner_lsu_q);
`else
    assign lsu_wins = lsu.arvalid;
`endif

    // State and grant registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant   <= 2'b00;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
        end
    end

    // Next-state: arbitrate in IDLE, wait for the AR handshake, then the R handshake
    always_comb begin
        state_d = state_q;
        grant_d = grant;
        case (state_q)
            IDLE: begin
                if (ifu.arvalid || lsu.arvalid) begin
                    state_d = ADDR;
                    grant_d = lsu_wins ? 2'b10 : 2'b01;
                end
            end
            ADDR: begin
                if (sram.arvalid && sram.arready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (r_done) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Channel routing: only the owner sees the SRAM, everyone else sees zeros
    always_comb begin
        sram.araddr  = '0;
        sram.arvalid = 1'b0;
        sram.rready  = 1'b0;
        ifu.arready  = 1'b0;
        ifu.rdata    = '0;
        ifu.rresp    = 2'b00;
        ifu.rvalid   = 1'b0;
        lsu.arready  = 1'b0;
        lsu.rdata    = '0;
        lsu.rresp    = 2'b00;
        lsu.rvalid   = 1'b0;
        case (state_q)
            ADDR: begin
                sram.araddr  = owner_araddr;
                sram.arvalid = owner_lsu ? lsu.arvalid : ifu.arvalid;
                if (owner_lsu) begin
                    lsu.arready = sram.arready;
                end else begin
                    ifu.arready = sram.arready;
                end
            end
            RESP: begin
                sram.rready = owner_lsu ? lsu.rready : ifu.rready;
                if (owner_lsu) begin
                    lsu.rvalid = sram.rvalid;
                    lsu.rdata  = sram.rdata;
                    lsu.rresp  = sram.rresp;
                end else begin
                    ifu.rvalid = sram.rvalid;
                    ifu.rdata  = sram.rdata;
                    ifu.rresp  = sram.rresp;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_sram_rd_arbiter.sv
// Bench for the SRAM read arbiter: directed scenarios followed by randomized
// IFU/LSU/SRAM traffic, all checked against a transaction-level model.
// Build with ARB_ROUND_ROBIN_EN defined to exercise the alternating-grant mode.
module tb_ysyx_23060208_sram_rd_arbiter;

    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;

    ysyx_23060208_sram_rd_arbiter_if #(.DATA_WIDTH(DW)) ifu_bus ();
    ysyx_23060208_sram_rd_arbiter_if #(.DATA_WIDTH(DW)) lsu_bus ();
    ysyx_23060208_sram_rd_arbiter_if #(.DATA_WIDTH(DW)) sram_bus ();

    ysyx_23060208_sram_rd_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .ifu   (ifu_bus),
        .lsu   (lsu_bus),
        .sram  (sram_bus),
        .grant (grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // requester side, index 0 = IFU, 1 = LSU; m_st 0 idle, 1 AR pending, 2 awaiting R
    int          m_st[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_goaddr[2];
    bit          m_go[2];
    bit          m_rearm[2];
    int          issued[2];
    int          delivered[2];
    logic [31:0] last_data[2];
    logic [1:0]  last_resp[2];
    logic        m_arvalid[2];
    logic        m_rready[2];

    // SRAM side; s_st 0 idle, 1 latency countdown, 2 presenting data
    int          s_st;
    int          s_delay;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [1:0]  s_resp;
    logic        s_arready;
    logic        s_rvalid;
    bit          force_resp_en;
    logic [1:0]  force_resp_val;

    bit          rand_mode;

    // reference model: who holds the port, whether its address was taken, last winner
    logic [1:0]  exp_grant;
    bit          ar_done;
    bit          last_lsu;
    int          ar_owner_log[$];
    logic [31:0] ar_addr_log[$];

    function automatic logic [31:0] memData(input logic [31:0] a);
        return ((a - 32'h8000_0000) * 32'h9E37_79B1) ^ 32'h0000_0413;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int m = 0; m < 2; m++) begin
            if (m_st[m] == 0 && (rand_mode ? ($urandom_range(0, 2) == 0) : m_go[m])) begin
                m_st[m]   = 1;
                m_addr[m] = rand_mode ? ($urandom & 32'hFFFF_FFFC) : m_goaddr[m];
                m_go[m]   = 1'b0;
                issued[m]++;
            end
            m_arvalid[m] = (m_st[m] == 1);
            m_rready[m]  = ($urandom_range(0, 2) != 0);
        end
        if (s_st == 1) begin
            if (s_delay == 0) s_st = 2;
            else s_delay--;
        end
        s_arready = ($urandom_range(0, 2) != 0);
        s_rvalid  = (s_st == 2);

        ifu_bus.araddr   = m_arvalid[0] ? m_addr[0] : $urandom;
        ifu_bus.arvalid  = m_arvalid[0];
        ifu_bus.rready   = m_rready[0];
        lsu_bus.araddr   = m_arvalid[1] ? m_addr[1] : $urandom;
        lsu_bus.arvalid  = m_arvalid[1];
        lsu_bus.rready   = m_rready[1];
        sram_bus.arready = s_arready;
        sram_bus.rvalid  = s_rvalid;
        sram_bus.rdata   = s_rvalid ? s_data : $urandom;
        sram_bus.rresp   = s_rvalid ? s_resp : 2'($urandom_range(0, 3));
    endtask

    task automatic sampleCheck();
        int          own;
        bit          arph;
        bit          rph;
        bit          lw;
        logic [31:0] routed_data;
        logic [1:0]  routed_resp;
        own  = exp_grant[1] ? 1 : 0;
        arph = (exp_grant != 2'b00) && !ar_done;
        rph  = (exp_grant != 2'b00) && ar_done;

        checkOutput("grant", 32'(grant), 32'(exp_grant));
        checkOutput("sram_arvalid", 32'(sram_bus.arvalid), 32'(arph && m_arvalid[own]));
        if (arph && m_arvalid[own]) checkOutput("sram_araddr", sram_bus.araddr, m_addr[own]);
        checkOutput("ifu_arready", 32'(ifu_bus.arready), 32'(arph && own == 0 && s_arready));
        checkOutput("lsu_arready", 32'(lsu_bus.arready), 32'(arph && own == 1 && s_arready));
        checkOutput("sram_rready", 32'(sram_bus.rready), 32'(rph && m_rready[own]));
        checkOutput("ifu_rvalid", 32'(ifu_bus.rvalid), 32'(rph && own == 0 && s_rvalid));
        checkOutput("lsu_rvalid", 32'(lsu_bus.rvalid), 32'(rph && own == 1 && s_rvalid));
        checkOutput("ifu_rdata", ifu_bus.rdata, (rph && own == 0) ? sram_bus.rdata : 32'h0);
        checkOutput("lsu_rdata", lsu_bus.rdata, (rph && own == 1) ? sram_bus.rdata : 32'h0);
        checkOutput("ifu_rresp", 32'(ifu_bus.rresp), (rph && own == 0) ? 32'(sram_bus.rresp) : 32'h0);
        checkOutput("lsu_rresp", 32'(lsu_bus.rresp), (rph && own == 1) ? 32'(sram_bus.rresp) : 32'h0);

        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                if (m_st[m] != 0) issued[m]--;
                m_st[m] = 0;
            end
            s_st      = 0;
            exp_grant = 2'b00;
            ar_done   = 1'b0;
            last_lsu  = 1'b0;
        end else if (exp_grant == 2'b00) begin
            if (m_arvalid[0] || m_arvalid[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                lw = m_arvalid[1] && (!m_arvalid[0] || !last_lsu);
`else
                lw = m_arvalid[1];
`endif
                exp_grant = lw ? 2'b10 : 2'b01;
            end
        end else if (arph) begin
            if (m_arvalid[own] && s_arready) begin
                ar_done  = 1'b1;
                m_st[own] = 2;
                s_st     = 1;
                s_delay  = int'($urandom_range(0, 3));
                s_addr   = sram_bus.araddr;
                s_data   = memData(s_addr);
                s_resp   = force_resp_en ? force_resp_val : 2'($urandom_range(0, 3));
                ar_owner_log.push_back(own);
                ar_addr_log.push_back(s_addr);
            end
        end else if (s_rvalid && m_rready[own]) begin
            routed_data    = (own == 1) ? lsu_bus.rdata : ifu_bus.rdata;
            routed_resp    = (own == 1) ? lsu_bus.rresp : ifu_bus.rresp;
            last_data[own] = routed_data;
            last_resp[own] = routed_resp;
            checkOutput("deliv_data", routed_data, memData(m_addr[own]));
            checkOutput("deliv_resp", 32'(routed_resp), 32'(s_resp));
            delivered[own]++;
            m_st[own] = 0;
            s_st      = 0;
            exp_grant = 2'b00;
            ar_done   = 1'b0;
            last_lsu  = (own == 1);
            if (m_rearm[own]) begin
                m_go[own]     = 1'b1;
                m_goaddr[own] = m_goaddr[own] + 32'd4;
            end
        end
    endtask

    task automatic runCycle();
        applyStimulus();
        #3;
        sampleCheck();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDelivered(input int m, input int target, input int budget);
        int n = 0;
        while (delivered[m] < target && n < budget) begin
            runCycle();
            n++;
        end
        checkOutput($sformatf("deliv_count%0d", m), 32'(delivered[m]), 32'(target));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_st[0] != 0 || m_st[1] != 0) && n < budget) begin
            runCycle();
            n++;
        end
        checkOutput("drain_idle", 32'(m_st[0] != 0 || m_st[1] != 0), 32'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        runCycle();
        rst = 1'b0;
        ar_owner_log.delete();
        ar_addr_log.delete();
    endtask

    initial begin
        int  n;
        bit  reached;
        int  d0;
        rst            = 1'b1;
        rand_mode      = 1'b0;
        force_resp_en  = 1'b0;
        force_resp_val = 2'b00;
        exp_grant      = 2'b00;
        ar_done        = 1'b0;
        last_lsu       = 1'b0;
        s_st           = 0;
        s_delay        = 0;
        for (int m = 0; m < 2; m++) begin
            m_st[m] = 0; m_go[m] = 1'b0; m_rearm[m] = 1'b0;
            issued[m] = 0; delivered[m] = 0; m_goaddr[m] = 32'h0;
            last_data[m] = 32'h0; last_resp[m] = 2'b00;
        end
        @(posedge clk);
        #1;
        repeat (2) runCycle();
        rst = 1'b0;

        // IFU-only fetch at the reset vector
        $display("[TB] IFU-only fetch");
        m_goaddr[0] = 32'h8000_0000;
        m_go[0]     = 1'b1;
        waitDelivered(0, 1, 40);
        checkOutput("ifu_fetch_data", last_data[0], 32'h0000_0413);
        checkOutput("lsu_untouched", 32'(delivered[1]), 32'h0);

        // simultaneous requests
        $display("[TB] simultaneous IFU and LSU");
        doReset();
        m_goaddr[0] = 32'h8000_0100;
        m_goaddr[1] = 32'h8000_2000;
        m_go[0]     = 1'b1;
        m_go[1]     = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        m_rearm[0] = 1'b1;
        m_rearm[1] = 1'b1;
        n = 0;
        while (ar_owner_log.size() < 4 && n < 200) begin
            runCycle();
            n++;
        end
        m_rearm[0] = 1'b0; m_rearm[1] = 1'b0;
        m_go[0] = 1'b0; m_go[1] = 1'b0;
        drain(60);
        checkOutput("rr_log_size", 32'(ar_owner_log.size() >= 4), 32'h1);
        if (ar_owner_log.size() >= 4) begin
            checkOutput("rr_grant0", 32'(ar_owner_log[0]), 32'd1);
            checkOutput("rr_grant1", 32'(ar_owner_log[1]), 32'd0);
            checkOutput("rr_grant2", 32'(ar_owner_log[2]), 32'd1);
            checkOutput("rr_grant3", 32'(ar_owner_log[3]), 32'd0);
        end
`else
        waitDelivered(0, delivered[0] + 1, 80);
        checkOutput("both_lsu_done", 32'(delivered[1]), 32'd1);
        checkOutput("fp_log_size", 32'(ar_owner_log.size()), 32'd2);
        if (ar_owner_log.size() == 2) begin
            checkOutput("fp_first_owner", 32'(ar_owner_log[0]), 32'd1);
            checkOutput("fp_second_owner", 32'(ar_owner_log[1]), 32'd0);
            checkOutput("fp_first_addr", ar_addr_log[0], 32'h8000_2000);
            checkOutput("fp_second_addr", ar_addr_log[1], 32'h8000_0100);
        end
`endif

        // error response forwarded unmodified
        $display("[TB] SLVERR on LSU read");
        force_resp_en  = 1'b1;
        force_resp_val = 2'b10;
        d0             = delivered[1];
        m_goaddr[1]    = 32'h8000_3000;
        m_go[1]        = 1'b1;
        waitDelivered(1, d0 + 1, 40);
        checkOutput("lsu_slverr", 32'(last_resp[1]), 32'h2);
        checkOutput("idle_after_err", 32'(grant), 32'h0);
        force_resp_en = 1'b0;

        // randomized traffic
        $display("[TB] random traffic");
        rand_mode = 1'b1;
        repeat (3000) runCycle();
        rand_mode = 1'b0;
        drain(60);

        // reset while a response is pending
        $display("[TB] reset during response phase");
        m_goaddr[0] = 32'h8000_0040;
        m_go[0]     = 1'b1;
        n           = 0;
        reached     = 1'b0;
        while (!reached && n < 60) begin
            runCycle();
            n++;
            reached = (exp_grant != 2'b00) && ar_done;
        end
        checkOutput("reached_resp", 32'(reached), 32'h1);
        rst = 1'b1;
        runCycle();
        rst = 1'b0;
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_ifu_rvalid", 32'(ifu_bus.rvalid), 32'h0);
        checkOutput("rst_lsu_rvalid", 32'(lsu_bus.rvalid), 32'h0);
        checkOutput("rst_sram_arvalid", 32'(sram_bus.arvalid), 32'h0);
        checkOutput("rst_sram_rready", 32'(sram_bus.rready), 32'h0);
        repeat (4) runCycle();

        checkOutput("ifu_served_once", 32'(delivered[0]), 32'(issued[0]));
        checkOutput("lsu_served_once", 32'(delivered[1]), 32'(issued[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
